lab3_cache_line_xfer_unit: RTL and testbench
============================================

Name: lab3_cache_line_xfer_unit

Overview:
- Transfer engine downstream of the cache controller.
- Turns one spill (dirty-line write-back) or refill (line fetch) command into WORDS_PER_LINE word-level memory requests, collects the in-order responses, and assembles refill data into a line buffer.
- Pulses req-done/resp-done status back to the controller FSM, then holds a completion handshake until the controller acknowledges it.

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, 2..16.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; byte stride per word is DATA_W/8.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cmd_val  in  1  command valid
- cmd_rdy  out  1  engine can accept a command (IDLE only)
- cmd_type  in  1  0 = refill (read), 1 = spill (write)
- cmd_line_addr  in  ADDR_W  line base address; low log2(WORDS_PER_LINE*DATA_W/8) bits are ignored and forced to 0
- cmd_line_data  in  WORDS_PER_LINE*DATA_W  spill data, word 0 in LSBs
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory ready
- mem_req_type  out  1  0 read, 1 write
- mem_req_addr  out  ADDR_W  word byte address
- mem_req_data  out  DATA_W  write data (0 for reads)
- mem_resp_val  in  1  memory response valid
- mem_resp_rdy  out  1  engine accepts response
- mem_resp_type  in  1  response type
- mem_resp_data  in  DATA_W  read data
- req_done  out  1  1-cycle pulse: last request handshaken
- resp_done  out  1  1-cycle pulse: last response handshaken
- done_val  out  1  transfer complete
- done_rdy  in  1  controller acknowledges completion
- done_type  out  1  latched cmd_type
- refill_line  out  WORDS_PER_LINE*DATA_W  assembled refill line
- type_err  out  1  sticky: response type differed from latched cmd_type

Behaviour:
- Reset is synchronous and active-high on clk. It forces: state IDLE; req_cnt = resp_cnt = 0; refill_line = 0; type_err = 0; all valid/rdy/pulse outputs 0 except cmd_rdy = 1.
- FSM states:
  - IDLE: cmd_rdy = 1. On cmd_val, latch type, aligned address and line data; clear counters; go to XFER next cycle.
  - XFER: mem_req_val = (req_cnt < WORDS_PER_LINE); mem_resp_rdy = (resp_cnt < req_cnt). When resp_cnt reaches WORDS_PER_LINE, go to DONE.
  - DONE: done_val = 1 held until done_rdy, then go to IDLE.
- Request fields: mem_req_addr = line_addr + req_cnt*(DATA_W/8). mem_req_data = word[req_cnt] of latched data for a spill, 0 for a refill. mem_req_type = latched type.
- req_cnt increments on each mem_req_val && mem_req_rdy. resp_cnt increments on each mem_resp_val && mem_resp_rdy.
- Counter width: log2(WORDS_PER_LINE)+1 bits, so the value WORDS_PER_LINE is representable and no wrap occurs.
- Refill response data is written into refill_line word[resp_cnt]. Spill responses are acks only; their data is discarded.
- Responses are assumed in order with at most WORDS_PER_LINE outstanding. A response is never accepted before its request has been handshaken.
- A request handshake and a response handshake in the same cycle are both legal and both counters update.
- req_done pulses in the cycle the final request handshakes. resp_done pulses in the cycle the final response handshakes.
- done_val rises the cycle after resp_done.
- mem_req_val, once asserted, stays high with stable fields until handshaken.
- refill_line holds its value until the next refill command is accepted, then clears to 0.
- cmd_val outside IDLE is ignored. A new command can be accepted no earlier than the cycle after the done_val && done_rdy handshake.
- type_err is set on any response whose type differs from the latched cmd_type. It is cleared only by reset or by the next command accept.
- Reset mid-transfer aborts: all state returns to reset values, and any in-flight responses arriving afterwards are not accepted (mem_resp_rdy = 0 in IDLE).
- Minimum latency with always-ready memory and 1-cycle response: cmd accept at T, requests at T+1..T+4, responses at T+2..T+5, done_val at T+6.

Test Plan:
- Refill, addr 0x1004, WORDS_PER_LINE=4, mem always ready, responses 0xA0..0xA3 one cycle after each request → request addrs 0x1000/0x1004/0x1008/0x100C; refill_line = {0xA3,0xA2,0xA1,0xA0}; req_done at T+4, resp_done at T+5, done_val at T+6 with done_type = 0.
- Spill, addr 0x2000, data {0xD3,0xD2,0xD1,0xD0}, mem_req_rdy low on alternate cycles → write data order 0xD0..0xD3, no request dropped or repeated, fields stable while stalled; done only after 4 acks; refill_line unchanged.
- Back-pressure on done: done_rdy held 0 for 5 cycles → done_val stays 1 and cmd_rdy stays 0; cmd_val asserted in that window is ignored; accepted only in the cycle after the done handshake.
- All 4 requests issued before any response, then 4 back-to-back responses → mem_resp_rdy high throughout, and resp_done pulses exactly once.
- Reset asserted after 2 requests of a refill → next cycle is IDLE, cmd_rdy = 1, refill_line = 0, mem_req_val = 0, and a late mem_resp_val is not accepted.
- Refill receiving a response with type = 1 → type_err = 1 stays set through done, then clears on the next cmd accept.

Source files
------------

// File: rtl/lab3_cache_line_xfer_unit.sv
// Line transfer engine: expands one spill/refill command into per-word memory
// requests, collects in-order responses, and holds a completion handshake.
module lab3_cache_line_xfer_unit #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_val,
    output logic                             cmd_rdy,
    input  logic                             cmd_type,
    input  logic [ADDR_W-1:0]                cmd_line_addr,
    input  logic [WORDS_PER_LINE*DATA_W-1:0] cmd_line_data,
    output logic                             mem_req_val,
    input  logic                             mem_req_rdy,
    output logic                             mem_req_type,
    output logic [ADDR_W-1:0]                mem_req_addr,
    output logic [DATA_W-1:0]                mem_req_data,
    input  logic                             mem_resp_val,
    output logic                             mem_resp_rdy,
    input  logic                             mem_resp_type,
    input  logic [DATA_W-1:0]                mem_resp_data,
    output logic                             req_done,
    output logic                             resp_done,
    output logic                             done_val,
    input  logic                             done_rdy,
    output logic                             done_type,
    output logic [WORDS_PER_LINE*DATA_W-1:0] refill_line,
    output logic                             type_err
);

    localparam int IDX_W   = $clog2(WORDS_PER_LINE);
    localparam int CNT_W   = IDX_W + 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int LINE_SH = IDX_W + BYTE_SH;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_SH) - ADDR_W'(1));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic                             type_reg;
    logic [ADDR_W-1:0]                addr_reg;
    logic [WORDS_PER_LINE*DATA_W-1:0] data_reg;
    logic [CNT_W-1:0]                 req_cnt_reg;
    logic [CNT_W-1:0]                 resp_cnt_reg;
    logic                             type_err_reg;
    logic [DATA_W-1:0]                refill_words_reg [WORDS_PER_LINE];
    logic [DATA_W-1:0]                spill_words [WORDS_PER_LINE];

    logic cmd_fire;
    logic req_fire;
    logic resp_fire;

    assign cmd_fire  = cmd_val && cmd_rdy;
    assign req_fire  = mem_req_val && mem_req_rdy;
    assign resp_fire = mem_resp_val && mem_resp_rdy;

    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
            assign spill_words[gi]                 = data_reg[gi*DATA_W +: DATA_W];
            assign refill_line[gi*DATA_W +: DATA_W] = refill_words_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Response acceptance is recomputed from counters here rather than from
    // mem_resp_rdy to keep the combinational graph free of self-reads.
    always_comb begin
        state_next   = state_reg;
        cmd_rdy      = 1'b0;
        mem_req_val  = 1'b0;
        mem_resp_rdy = 1'b0;
        done_val     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_req_val  = (req_cnt_reg < CNT_FULL);
                mem_resp_rdy = (resp_cnt_reg < req_cnt_reg);
                if (mem_resp_val && (resp_cnt_reg < req_cnt_reg) && (resp_cnt_reg == CNT_LAST)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_val = 1'b1;
                if (done_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_req_type = type_reg;
    assign mem_req_addr = addr_reg + (ADDR_W'(req_cnt_reg) << BYTE_SH);
    assign mem_req_data = type_reg ? spill_words[req_cnt_reg[IDX_W-1:0]] : '0;
    assign req_done     = req_fire && (req_cnt_reg == CNT_LAST);
    assign resp_done    = resp_fire && (resp_cnt_reg == CNT_LAST);
    assign done_type    = type_reg;
    assign type_err     = type_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            type_reg     <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            req_cnt_reg  <= '0;
            resp_cnt_reg <= '0;
            type_err_reg <= 1'b0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                refill_words_reg[i] <= '0;
            end
        end else begin
            if (cmd_fire) begin
                type_reg     <= cmd_type;
                addr_reg     <= cmd_line_addr & LINE_MASK;
                data_reg     <= cmd_line_data;
                req_cnt_reg  <= '0;
                resp_cnt_reg <= '0;
                type_err_reg <= 1'b0;
                // A spill leaves the last refilled line visible to the controller.
                if (!cmd_type) begin
                    for (int i = 0; i < WORDS_PER_LINE; i++) begin
                        refill_words_reg[i] <= '0;
                    end
                end
            end
            if (req_fire) begin
                req_cnt_reg <= req_cnt_reg + CNT_W'(1);
            end
            if (resp_fire) begin
                resp_cnt_reg <= resp_cnt_reg + CNT_W'(1);
                if (mem_resp_type != type_reg) begin
                    type_err_reg <= 1'b1;
                end
                if (!type_reg) begin
                    refill_words_reg[resp_cnt_reg[IDX_W-1:0]] <= mem_resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lab3_cache_line_xfer_unit.sv
// Directed bench for the line transfer engine: refill, stalled spill, done
// back-pressure, burst responses with a type error, and mid-transfer reset.
module tb_lab3_cache_line_xfer_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_val;
    logic         cmd_rdy;
    logic         cmd_type;
    logic [31:0]  cmd_line_addr;
    logic [127:0] cmd_line_data;
    logic         mem_req_val;
    logic         mem_req_rdy;
    logic         mem_req_type;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_data;
    logic         mem_resp_val;
    logic         mem_resp_rdy;
    logic         mem_resp_type;
    logic [31:0]  mem_resp_data;
    logic         req_done;
    logic         resp_done;
    logic         done_val;
    logic         done_rdy;
    logic         done_type;
    logic [127:0] refill_line;
    logic         type_err;

    int total = 0;
    int bad   = 0;

    lab3_cache_line_xfer_unit #(
        .WORDS_PER_LINE(4),
        .ADDR_W        (32),
        .DATA_W        (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_val      (cmd_val),
        .cmd_rdy      (cmd_rdy),
        .cmd_type     (cmd_type),
        .cmd_line_addr(cmd_line_addr),
        .cmd_line_data(cmd_line_data),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_type (mem_req_type),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .mem_resp_type(mem_resp_type),
        .mem_resp_data(mem_resp_data),
        .req_done     (req_done),
        .resp_done    (resp_done),
        .done_val     (done_val),
        .done_rdy     (done_rdy),
        .done_type    (done_type),
        .refill_line  (refill_line),
        .type_err     (type_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_req;
        int n_resp;
        int pend;
        int resp_done_cnt;
        bit pend_add;
        bit stalled;
        bit done_seen;

        reset         = 1'b1;
        cmd_val       = 1'b0;
        cmd_type      = 1'b0;
        cmd_line_addr = '0;
        cmd_line_data = '0;
        mem_req_rdy   = 1'b0;
        mem_resp_val  = 1'b0;
        mem_resp_type = 1'b0;
        mem_resp_data = '0;
        done_rdy      = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_req_val", mem_req_val, 0);
        chk("rst_resp_rdy", mem_resp_rdy, 0);
        chk("rst_done_val", done_val, 0);
        chk("rst_refill", refill_line, 0);
        chk("rst_type_err", type_err, 0);

        // Refill at 0x1004, always-ready memory, responses one cycle behind.
        cmd_val = 1'b1; cmd_type = 1'b0; cmd_line_addr = 32'h1004;
        #1 chk("t1_cmd_rdy", cmd_rdy, 1);
        tick();
        cmd_val = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            mem_req_rdy   = 1'b1;
            mem_resp_val  = (c >= 2 && c <= 5);
            mem_resp_type = 1'b0;
            mem_resp_data = 32'hA0 + c - 2;
            #1;
            if (c <= 4) begin
                chk("t1_req_val", mem_req_val, 1);
                chk("t1_req_addr", mem_req_addr, 32'h1000 + 4 * (c - 1));
                chk("t1_req_data", mem_req_data, 0);
                chk("t1_req_type", mem_req_type, 0);
                $display("t1 req addr=%h type=%0d", mem_req_addr, mem_req_type);
            end else begin
                chk("t1_req_val_off", mem_req_val, 0);
            end
            chk("t1_req_done", req_done, c == 4);
            chk("t1_resp_rdy", mem_resp_rdy, (c >= 2 && c <= 5));
            chk("t1_resp_done", resp_done, c == 5);
            chk("t1_done_val", done_val, c == 6);
            tick();
        end
        mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
        #1;
        chk("t1_done_hold", done_val, 1);
        chk("t1_done_type", done_type, 0);
        chk("t1_refill", refill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
        #1;
        chk("t1_idle_cmd_rdy", cmd_rdy, 1);
        chk("t1_idle_done_val", done_val, 0);

        // Spill at 0x2000 with the memory stalling on alternate cycles.
        cmd_val = 1'b1; cmd_type = 1'b1; cmd_line_addr = 32'h2000;
        cmd_line_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        tick();
        cmd_val = 1'b0;
        n_req = 0; n_resp = 0; pend = 0; stalled = 0; done_seen = 0;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            mem_req_rdy   = cyc[0];
            mem_resp_val  = (pend > 0);
            mem_resp_type = 1'b1;
            mem_resp_data = 32'hFFFF_FFFF;
            pend_add      = 0;
            #1;
            if (done_val) begin
                done_seen = 1;
            end else begin
                if (stalled) chk("t2_val_hold", mem_req_val, 1);
                if (mem_req_val) begin
                    chk("t2_req_addr", mem_req_addr, 32'h2000 + 4 * n_req);
                    chk("t2_req_data", mem_req_data, 32'hD0 + n_req);
                    chk("t2_req_type", mem_req_type, 1);
                    if (mem_req_rdy) begin
                        $display("t2 req addr=%h data=%h", mem_req_addr, mem_req_data);
                        n_req++;
                        pend_add = 1;
                        stalled  = 0;
                    end else begin
                        stalled = 1;
                    end
                end
                if (mem_resp_val) begin
                    chk("t2_resp_rdy", mem_resp_rdy, 1);
                    n_resp++;
                    pend--;
                end
                if (pend_add) pend++;
                tick();
            end
        end
        mem_resp_val = 1'b0; mem_req_rdy = 1'b0;
        chk("t2_done_seen", done_seen, 1);
        chk("t2_n_req", n_req, 4);
        chk("t2_n_resp", n_resp, 4);
        chk("t2_done_type", done_type, 1);
        chk("t2_refill_kept", refill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("t2_type_err", type_err, 0);

        // Hold off the done handshake while a new command waits.
        for (int k = 0; k < 5; k++) begin
            cmd_val = 1'b1; cmd_type = 1'b0; cmd_line_addr = 32'h3000;
            #1;
            chk("t3_done_val", done_val, 1);
            chk("t3_cmd_rdy", cmd_rdy, 0);
            tick();
        end
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;
        #1;
        chk("t3_idle_cmd_rdy", cmd_rdy, 1);
        chk("t3_not_early", mem_req_val, 0);
        tick();
        cmd_val = 1'b0;
        #1;
        chk("t3_req_val", mem_req_val, 1);
        chk("t3_req_addr", mem_req_addr, 32'h3000);
        chk("t3_refill_clr", refill_line, 0);

        // All requests first, then four back-to-back responses; word 2 has a bad type.
        for (int c = 0; c < 4; c++) begin
            mem_req_rdy = 1'b1; mem_resp_val = 1'b0;
            #1;
            chk("t4_req_val", mem_req_val, 1);
            chk("t4_req_done", req_done, c == 3);
            chk("t4_resp_rdy_pre", mem_resp_rdy, c > 0);
            tick();
        end
        mem_req_rdy = 1'b0;
        resp_done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = 32'hB0 + c;
            mem_resp_type = (c == 2);
            #1;
            if (c == 3) chk("t4_type_err_set", type_err, 1);
            chk("t4_req_val_off", mem_req_val, 0);
            chk("t4_resp_rdy", mem_resp_rdy, 1);
            if (resp_done) resp_done_cnt++;
            $display("t4 resp data=%h type=%0d", mem_resp_data, mem_resp_type);
            tick();
        end
        mem_resp_val = 1'b0; mem_resp_type = 1'b0;
        #1;
        chk("t4_resp_done_cnt", resp_done_cnt, 1);
        chk("t4_done_val", done_val, 1);
        chk("t4_refill", refill_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        chk("t4_type_err_hold", type_err, 1);
        done_rdy = 1'b1;
        tick();
        done_rdy = 1'b0;

        // Refill at 0x4008 aborted by reset after two requests and one response.
        cmd_val = 1'b1; cmd_type = 1'b0; cmd_line_addr = 32'h4008;
        tick();
        cmd_val = 1'b0;
        #1;
        chk("t5_type_err_clr", type_err, 0);
        chk("t5_req_addr", mem_req_addr, 32'h4000);
        for (int c = 0; c < 2; c++) begin
            mem_req_rdy   = 1'b1;
            mem_resp_val  = (c == 1);
            mem_resp_type = 1'b0;
            mem_resp_data = 32'hC0;
            tick();
        end
        mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
        #1;
        chk("t5_partial", refill_line, 128'hC0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_resp_val  = 1'b1;
        mem_resp_data = 32'hEE;
        #1;
        chk("t5_cmd_rdy", cmd_rdy, 1);
        chk("t5_refill", refill_line, 0);
        chk("t5_req_val", mem_req_val, 0);
        chk("t5_resp_rdy", mem_resp_rdy, 0);
        chk("t5_done_val", done_val, 0);
        tick();
        mem_resp_val = 1'b0;
        #1;
        chk("t5_refill_after", refill_line, 0);
        chk("t5_still_idle", cmd_rdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
